// File: rtl/output_port_arbiter_pkg.sv
// Shared router constants and output-arbiter state encodings.
package output_port_arbiter_pkg;

  localparam int DIRECTIONS = 5;
  localparam int BITS_DIR   = 3;

  localparam int DIR_LOCAL = 0;
  localparam int DIR_NORTH = 1;
  localparam int DIR_EAST  = 2;
  localparam int DIR_SOUTH = 3;
  localparam int DIR_WEST  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_SEND = 2'd2
  } arb_state_t;

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req found searching from ptr+1 upward, wrapping.
module output_port_arbiter_rr_pick
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_IN = DIRECTIONS,
  parameter int IDX_W  = BITS_DIR
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] win,
  output logic [IDX_W-1:0]  win_idx
);

  always_comb begin
    int   idx;
    logic found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NUM_IN; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output round-robin allocator: grants one input, pops its flit, holds grant until tx_done or watchdog.
// Optional flit counter enabled by defining ARB_FLIT_COUNT_EN.
module output_port_arbiter
  import output_port_arbiter_pkg::*;
#(
  parameter int NUM_IN   = DIRECTIONS,
  parameter int MAX_SEND = 64,
  parameter int CNT_W    = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IN-1:0] req,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [NUM_IN-1:0] grant,
  output logic [NUM_IN-1:0] pop,
  output logic              tx_start,
  output logic              timeout,
  output logic [CNT_W-1:0]  flit_count
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int WD_W  = (MAX_SEND > 1) ? $clog2(MAX_SEND) : 1;
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(MAX_SEND - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_IN - 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [NUM_IN-1:0] grant_d, pop_d;
  logic              tx_start_d, timeout_d;
  logic [NUM_IN-1:0] win;
  logic [IDX_W-1:0]  win_idx;

  output_port_arbiter_rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= PTR_RESET;
      wd_q     <= '0;
      grant    <= '0;
      pop      <= '0;
      tx_start <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wd_q     <= wd_d;
      grant    <= grant_d;
      pop      <= pop_d;
      tx_start <= tx_start_d;
      timeout  <= timeout_d;
    end
  end

  // Pointer is committed together with the grant so the winner drops to lowest priority.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    grant_d    = grant;
    pop_d      = '0;
    tx_start_d = 1'b0;
    timeout_d  = timeout;
    case (state_q)
      ARB_IDLE: begin
        if (|req && !tx_busy) begin
          grant_d    = win;
          pop_d      = win;
          tx_start_d = 1'b1;
          ptr_d      = win_idx;
          state_d    = ARB_LOAD;
        end
      end
      ARB_LOAD: begin
        wd_d    = '0;
        state_d = ARB_SEND;
      end
      ARB_SEND: begin
        if (tx_done) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (wd_q == WD_LAST) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

`ifdef ARB_FLIT_COUNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (state_q == ARB_LOAD && count_q != '1) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign flit_count = count_q;
`else
  assign flit_count = '0;
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter with a tx serializer model and grant scoreboard.
module tb_output_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  req = '0;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b0;
  logic [4:0]  grant, pop;
  logic        tx_start, timeout;
  logic [19:0] flit_count;

  int passed = 0;
  int total  = 0;
  logic [4:0] exp_q[$];

  int tx_delay    = 34;
  bit tx_model_en = 1'b1;
  int tx_cd       = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .NUM_IN   (5),
    .MAX_SEND (64),
    .CNT_W    (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant      (grant),
    .pop        (pop),
    .tx_start   (tx_start),
    .timeout    (timeout),
    .flit_count (flit_count)
  );

  // Serializer model: one-cycle tx_done pulse tx_delay cycles after tx_start
  always @(negedge clk) begin
    tx_done = 1'b0;
    if (!reset) begin
      tx_cd = 0;
    end else begin
      if (tx_cd > 0) begin
        tx_cd = tx_cd - 1;
        if (tx_cd == 0) tx_done = 1'b1;
      end
      if (tx_start === 1'b1 && tx_model_en) tx_cd = tx_delay;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    req = '0;
    tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant === 5'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    total++; if (grant !== 5'b0) $display("FAIL reset_grant got=%b exp=00000", grant); else passed++;
    total++; if (pop !== 5'b0) $display("FAIL reset_pop got=%b exp=00000", pop); else passed++;
    total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got=%b exp=0", tx_start); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout); else passed++;
    total++; if (flit_count !== 20'd0) $display("FAIL reset_flit_count got=%0d exp=0", flit_count); else passed++;
  endtask

  task automatic test_single();
    logic [4:0] exp;
    int gap;
    bit ok;
    apply_reset();
    req = 5'b00001;
    exp_q.push_back(5'b00001);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_start !== 1'b1) $display("FAIL single_latency tx_start got=%b exp=1", tx_start); else passed++;
    total++; if (grant !== exp) $display("FAIL single_grant got=%b exp=%b", grant, exp); else passed++;
    total++; if (pop !== exp) $display("FAIL single_pop got=%b exp=%b", pop, exp); else passed++;
    exp_q.push_back(5'b00001);
    @(negedge clk);
    total++;
    if (pop !== 5'b0 || tx_start !== 1'b0 || grant !== exp)
      $display("FAIL single_send got pop=%b tx_start=%b grant=%b exp pop=00000 tx_start=0 grant=%b",
               pop, tx_start, grant, exp);
    else passed++;
    gap = 1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      gap++;
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    req = '0;
    exp = exp_q.pop_front();
    total++; if (!ok || gap != tx_delay + 2) $display("FAIL single_loop_len got=%0d exp=%0d", gap, tx_delay + 2); else passed++;
    total++; if (grant !== exp) $display("FAIL single_regrant got=%b exp=%b", grant, exp); else passed++;
    wait_idle(60, ok);
    total++; if (!ok) $display("FAIL single_idle got=grant %b exp=00000", grant); else passed++;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp;
    bit ok;
    apply_reset();
    exp_q.push_back(5'b00001);
    exp_q.push_back(5'b00010);
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b01000);
    exp_q.push_back(5'b10000);
    exp_q.push_back(5'b00001);
    req = 5'b11111;
    while (exp_q.size() > 0) begin
      wait_start(60, ok);
      exp = exp_q.pop_front();
      total++;
      if (!ok) $display("FAIL rr_grant got=no tx_start exp=%b", exp);
      else if (grant !== exp) $display("FAIL rr_grant got=%b exp=%b", grant, exp);
      else passed++;
    end
    req = '0;
    wait_idle(60, ok);
    total++; if (!ok) $display("FAIL rr_idle got=grant %b exp=00000", grant); else passed++;
  endtask

  task automatic test_wrap();
    logic [4:0] exp;
    bit ok;
    apply_reset();
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b10000);
    req = 5'b10100;
    wait_start(5, ok);
    exp = exp_q.pop_front();
    total++; if (!ok || grant !== exp) $display("FAIL wrap_first got=%b exp=%b", grant, exp); else passed++;
    @(negedge clk);
    req = 5'b00011;
    repeat (3) @(negedge clk);
    total++; if (grant !== 5'b00100) $display("FAIL wrap_req_ignored got=%b exp=00100", grant); else passed++;
    req = 5'b10100;
    wait_start(60, ok);
    exp = exp_q.pop_front();
    total++; if (!ok || grant !== exp) $display("FAIL wrap_second got=%b exp=%b", grant, exp); else passed++;
    req = '0;
    wait_idle(60, ok);
    total++; if (!ok) $display("FAIL wrap_idle got=grant %b exp=00000", grant); else passed++;
  endtask

  task automatic test_busy();
    bit ok;
    @(negedge clk);
    tx_busy = 1'b1;
    req = 5'b00010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (grant !== 5'b0) $display("FAIL busy_hold cycle=%0d got=%b exp=00000", i, grant); else passed++;
    end
    tx_busy = 1'b0;
    @(negedge clk);
    total++;
    if (grant !== 5'b00010 || tx_start !== 1'b1)
      $display("FAIL busy_release got grant=%b tx_start=%b exp grant=00010 tx_start=1", grant, tx_start);
    else passed++;
    @(negedge clk);
    tx_busy = 1'b1;
    req = '0;
    wait_idle(40, ok);
    total++; if (!ok) $display("FAIL busy_in_send_done got=grant %b exp=00000", grant); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL busy_in_send_timeout got=%b exp=0", timeout); else passed++;
    tx_busy = 1'b0;
  endtask

  task automatic test_done_at_expiry();
    bit ok;
    apply_reset();
    tx_delay = 64;
    req = 5'b00001;
    wait_start(5, ok);
    req = '0;
    total++; if (!ok) $display("FAIL tie_start got=no tx_start exp=tx_start"); else passed++;
    wait_idle(80, ok);
    total++; if (!ok) $display("FAIL tie_idle got=grant %b exp=00000", grant); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL tie_timeout got=%b exp=0", timeout); else passed++;
    tx_delay = 34;
  endtask

  task automatic test_timeout();
    bit ok;
    int sends;
    tx_model_en = 1'b0;
    req = 5'b00001;
    wait_start(5, ok);
    req = '0;
    sends = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant === 5'b0) break;
      sends++;
    end
    total++; if (!ok || sends != 64) $display("FAIL timeout_send_len got=%0d exp=64", sends); else passed++;
    total++; if (timeout !== 1'b1) $display("FAIL timeout_set got=%b exp=1", timeout); else passed++;
    tx_model_en = 1'b1;
    req = 5'b00001;
    wait_start(5, ok);
    req = '0;
    wait_idle(40, ok);
    total++; if (!ok) $display("FAIL timeout_good_flit got=grant %b exp=00000", grant); else passed++;
    total++; if (timeout !== 1'b1) $display("FAIL timeout_sticky got=%b exp=1", timeout); else passed++;
  endtask

  task automatic test_flit_count();
    bit ok;
    bit all_ok;
    logic [19:0] exp_cnt;
`ifdef ARB_FLIT_COUNT_EN
    exp_cnt = 20'd7;
`else
    exp_cnt = 20'd0;
`endif
    apply_reset();
    all_ok = 1'b1;
    req = 5'b00001;
    for (int k = 0; k < 7; k++) begin
      wait_start(60, ok);
      if (!ok) all_ok = 1'b0;
      if (k == 6) req = '0;
    end
    wait_idle(60, ok);
    total++; if (!all_ok || !ok) $display("FAIL count_flits got=stalled exp=7 flits"); else passed++;
    total++; if (flit_count !== exp_cnt) $display("FAIL count_value got=%0d exp=%0d", flit_count, exp_cnt); else passed++;
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    req = 5'b00001;
    wait_start(5, ok);
    repeat (5) @(negedge clk);
    req = '0;
    total++; if (!ok || grant !== 5'b00001) $display("FAIL midrst_pre got=%b exp=00001", grant); else passed++;
    reset = 1'b0;
    #1;
    total++; if (grant !== 5'b0) $display("FAIL midrst_grant got=%b exp=00000", grant); else passed++;
    total++; if (pop !== 5'b0 || tx_start !== 1'b0) $display("FAIL midrst_pulses got pop=%b tx_start=%b exp 0", pop, tx_start); else passed++;
    total++; if (flit_count !== 20'd0) $display("FAIL midrst_count got=%0d exp=0", flit_count); else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (grant !== 5'b0 || tx_start !== 1'b0) $display("FAIL midrst_after got grant=%b tx_start=%b exp 0", grant, tx_start); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=still running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_busy();
    test_done_at_expiry();
    test_timeout();
    test_flit_count();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
